// File: rtl/maxpool_window_unit_pkg.sv
// Shared definitions for the max-pool window unit: FSM state encoding and default sizing.
package maxpool_window_unit_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MAX_WIN = 16;

endpackage

// File: rtl/maxpool_window_unit_lane.sv
// One channel of the pooler: holds the running maximum and produces the lane value
// the window would have if the current beat were its last.
module maxpool_window_unit_lane #(
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_first,
  input  logic                     i_accept,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_pooled
);

  logic signed [DATA_W-1:0] run_max;

  // First beat of a window loads without comparing; ties keep the stored value.
  always_comb begin
    o_pooled = run_max;
    if (i_first || (i_data > run_max)) begin
      o_pooled = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      run_max <= '0;
    end else if (i_clear) begin
      run_max <= '0;
    end else if (i_accept) begin
      run_max <= o_pooled;
    end
  end

endmodule

// File: rtl/maxpool_window_unit.sv
// Streaming per-lane max-pool over a runtime window, with bypass and a valid/ready output register.
// Optional build macro MAXPOOL_RELU_EN clamps negative pooled lanes to zero at output load.
module maxpool_window_unit
  import maxpool_window_unit_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_WIN = DEF_MAX_WIN,
  parameter int CNT_W   = $clog2(MAX_WIN + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_maxpool,
  input  logic [CNT_W-1:0]       i_win_len,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N_CH*DATA_W-1:0] i_result,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [N_CH*DATA_W-1:0] o_max,
  output logic                   o_busy
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        win_norm;
  logic [CNT_W-1:0]        eff_len;
  logic                    first;
  logic                    accept;
  logic                    last;
  logic [N_CH*DATA_W-1:0]  out_next;

  assign o_ready = !o_valid || i_ready;
  assign accept  = i_valid && o_ready;
  assign first   = (state_q == ST_IDLE);
  assign o_busy  = (cnt_q != '0);

  // Bypass and a zero length both collapse to a one-beat window.
  always_comb begin
    win_norm = i_win_len;
    if (!i_maxpool || (i_win_len == '0)) begin
      win_norm = CNT_W'(1);
    end else if (i_win_len > CNT_W'(MAX_WIN)) begin
      win_norm = CNT_W'(MAX_WIN);
    end
  end

  assign eff_len = first ? win_norm : len_q;
  assign last    = accept && ((cnt_q + CNT_W'(1)) == eff_len);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (accept) begin
      if (first) begin
        len_d = win_norm;
      end
      if (last) begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= CNT_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    logic signed [DATA_W-1:0] pooled;

    maxpool_window_unit_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (i_clear),
      .i_first  (first),
      .i_accept (accept),
      .i_data   (i_result[k*DATA_W +: DATA_W]),
      .o_pooled (pooled)
    );

`ifdef MAXPOOL_RELU_EN
    assign out_next[k*DATA_W +: DATA_W] = pooled[DATA_W-1] ? '0 : pooled;
`else
    assign out_next[k*DATA_W +: DATA_W] = pooled;
`endif
  end

  // A window completing on the same edge as a downstream pop keeps o_valid high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_max   <= '0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end else if (last) begin
      o_valid <= 1'b1;
      o_max   <= out_next;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
